// File: rtl/q1_4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | q1_4 : even-ratio clock divider, registered 50% duty output clk2.        |
// | Optional tick strobe on each clk2 rise when Q1_4_TICK_EN is defined.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module q1_4 #(
    parameter int DIV = 2,
    parameter int CW  = (DIV / 2 <= 1) ? 1 : $clog2(DIV / 2)
) (
    input  logic clk,
    input  logic rst_n,
    output logic clk2
`ifdef Q1_4_TICK_EN
    ,
    output logic tick
`endif
);

    localparam logic [CW-1:0] C_LAST = CW'(DIV / 2 - 1);

    if (DIV < 2 || (DIV % 2) != 0) begin : g_div_check
        $fatal(1, "q1_4: DIV must be an even integer >= 2");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          clk2_q;
    logic          clk2_d;
    logic          wrap;

    // '>=' also folds any unreachable counter value back to zero.
    always_comb begin
        wrap   = (cnt_q >= C_LAST);
        cnt_d  = wrap ? '0 : cnt_q + CW'(1);
        clk2_d = clk2_q ^ wrap;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            clk2_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            clk2_q <= clk2_d;
        end
    end

    assign clk2 = clk2_q;

`ifdef Q1_4_TICK_EN
    logic tick_q;
    logic tick_d;

    // Registered alongside clk2 so it is high exactly in clk2's first high cycle.
    always_comb begin
        tick_d = wrap & ~clk2_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_q1_4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_q1_4 : scoreboard bench for q1_4 at DIV = 2, 4, 6, 8 with random       |
// | reset pulses. Revision: 1.0                                              |
// +--------------------------------------------------------------------------+
module tb_q1_4;

    localparam int N_CYC = 3000;
    localparam int DIVS [4] = '{2, 4, 6, 8};

    typedef struct {
        logic [3:0] clk2;
        logic [3:0] tick;
        int         cnt4;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [3:0] clk2_w;
    logic [3:0] tick_w;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   k;
    int   rst_len;

    initial clk = 1'b0;
    always #10 clk = ~clk;

`ifdef Q1_4_TICK_EN
    q1_4 #(.DIV(2)) u_div2 (.clk(clk), .rst_n(rst_n), .clk2(clk2_w[0]), .tick(tick_w[0]));
    q1_4 #(.DIV(4)) u_div4 (.clk(clk), .rst_n(rst_n), .clk2(clk2_w[1]), .tick(tick_w[1]));
    q1_4 #(.DIV(6)) u_div6 (.clk(clk), .rst_n(rst_n), .clk2(clk2_w[2]), .tick(tick_w[2]));
    q1_4 #(.DIV(8)) u_div8 (.clk(clk), .rst_n(rst_n), .clk2(clk2_w[3]), .tick(tick_w[3]));
`else
    q1_4 #(.DIV(2)) u_div2 (.clk(clk), .rst_n(rst_n), .clk2(clk2_w[0]));
    q1_4 #(.DIV(4)) u_div4 (.clk(clk), .rst_n(rst_n), .clk2(clk2_w[1]));
    q1_4 #(.DIV(6)) u_div6 (.clk(clk), .rst_n(rst_n), .clk2(clk2_w[2]));
    q1_4 #(.DIV(8)) u_div8 (.clk(clk), .rst_n(rst_n), .clk2(clk2_w[3]));
    assign tick_w = 4'b0;
`endif

    // Reference: k = rising edges with rst_n=1 since the last reset edge.
    // clk2 is high during odd-numbered half periods; tick marks each rise.
    function automatic exp_t model(input int kk);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.clk2[i] = ((kk / (DIVS[i] / 2)) % 2) == 1;
            e.tick[i] = (kk % DIVS[i]) == (DIVS[i] / 2);
        end
        e.cnt4 = kk % 2;
        return e;
    endfunction

    // Stimulus: rst_n chosen for the upcoming edge, expected state pushed.
    initial begin
        rst_n   = 1'b0;
        k       = 0;
        rst_len = 0;
        for (int n = 0; n < N_CYC; n++) begin
            if (n < 5) begin
                rst_n = 1'b0;
            end else if (rst_len > 0) begin
                rst_n = 1'b0;
                rst_len--;
            end else if ($urandom_range(0, 59) == 0) begin
                rst_n   = 1'b0;
                rst_len = int'($urandom_range(0, 2));
            end else begin
                rst_n = 1'b1;
            end
            k = rst_n ? k + 1 : 0;
            sb.push_back(model(k));
            @(posedge clk);
            #2;
        end
    end

    // Monitor: samples 1 ns after each edge and checks against the queue head.
    initial begin
        exp_t e;
        checks = 0;
        errors = 0;
        for (int n = 0; n < N_CYC; n++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty cycle %0d", n);
            end else begin
                e = sb.pop_front();
                for (int i = 0; i < 4; i++) begin
                    checks++;
                    if (clk2_w[i] !== e.clk2[i]) begin
                        errors++;
                        $display("FAIL clk2 DIV=%0d cycle %0d got %b expected %b",
                                 DIVS[i], n, clk2_w[i], e.clk2[i]);
                    end
`ifdef Q1_4_TICK_EN
                    checks++;
                    if (tick_w[i] !== e.tick[i]) begin
                        errors++;
                        $display("FAIL tick DIV=%0d cycle %0d got %b expected %b",
                                 DIVS[i], n, tick_w[i], e.tick[i]);
                    end
`endif
                end
                checks++;
                if (int'(u_div4.cnt_q) != e.cnt4) begin
                    errors++;
                    $display("FAIL cnt DIV=4 cycle %0d got %0d expected %0d",
                             n, u_div4.cnt_q, e.cnt4);
                end
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
